// File: rtl/output_mem_wr_if.sv
// output_mem_wr_if: command inputs and per-bank write outputs of output_mem_wr_ctrl.
interface output_mem_wr_if #(parameter int WIDTH_HEIGHT = 4);
    logic start;
    logic [7:0] base_addr;
    logic [7:0] num_rows;
    logic [WIDTH_HEIGHT-1:0] wr_en;
    logic [WIDTH_HEIGHT*8-1:0] wr_addr;
    logic busy;
    logic done;
    modport master (output start, base_addr, num_rows, input wr_en, wr_addr, busy, done);
    modport slave (input start, base_addr, num_rows, output wr_en, wr_addr, busy, done);
endinterface

// File: rtl/output_mem_wr_ctrl.sv
// output_mem_wr_ctrl: turns one start command into per-bank write enables and addresses.
// OUTMEM_WR_SKEW_EN defined: column i lags column 0 by i cycles to follow the array wavefront.
module output_mem_wr_ctrl #(parameter int WIDTH_HEIGHT = 4) (
    input logic clk,
    input logic reset_n,
    output_mem_wr_if.slave io
);
    localparam int W = WIDTH_HEIGHT;
`ifdef OUTMEM_WR_SKEW_EN
    localparam bit SKEW = 1'b1;
`else
    localparam bit SKEW = 1'b0;
`endif
    localparam bit DRAIN_EN = SKEW && (W > 1);
    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;
    state_t state, state_d;
    logic [7:0] addr_q, rows_q, row_cnt, drain_cnt;
    logic [7:0] addr_q_d, rows_q_d, row_cnt_d, drain_cnt_d;
    logic busy, busy_d, done, done_d, zero_q, zero_q_d, en0_d;
    logic [7:0] addr0_d;
    logic [W-1:0] wr_en;
    logic [W*8-1:0] wr_addr;
    always_comb begin
        state_d = state;
        addr_q_d = addr_q;
        rows_q_d = rows_q;
        row_cnt_d = row_cnt;
        drain_cnt_d = drain_cnt;
        busy_d = busy;
        done_d = 1'b0;
        zero_q_d = 1'b0;
        en0_d = 1'b0;
        addr0_d = wr_addr[7:0];
        case (state)
            IDLE: begin
                busy_d = 1'b0;
                done_d = zero_q;
                if (io.start && !busy) begin
                    addr_q_d = io.base_addr;
                    rows_q_d = io.num_rows;
                    row_cnt_d = '0;
                    zero_q_d = io.num_rows == 8'd0;
                    state_d = io.num_rows == 8'd0 ? IDLE : ISSUE;
                end
            end
            ISSUE: begin
                busy_d = 1'b1;
                en0_d = 1'b1;
                addr0_d = addr_q + row_cnt;
                row_cnt_d = row_cnt + 8'd1;
                drain_cnt_d = '0;
                if (row_cnt == rows_q - 8'd1) begin
                    state_d = DRAIN_EN ? DRAIN : IDLE;
                    done_d = !DRAIN_EN;
                end
            end
            DRAIN: begin
                // done is raised when the last column sees its last row; leave one cycle later
                drain_cnt_d = drain_cnt + 8'd1;
                done_d = !done && drain_cnt == 8'(W - 2);
                busy_d = !done;
                state_d = done ? IDLE : DRAIN;
            end
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
            addr_q <= '0;
            rows_q <= '0;
            row_cnt <= '0;
            drain_cnt <= '0;
            busy <= 1'b0;
            done <= 1'b0;
            zero_q <= 1'b0;
            wr_en <= '0;
            wr_addr <= '0;
        end else begin
            state <= state_d;
            addr_q <= addr_q_d;
            rows_q <= rows_q_d;
            row_cnt <= row_cnt_d;
            drain_cnt <= drain_cnt_d;
            busy <= busy_d;
            done <= done_d;
            zero_q <= zero_q_d;
            wr_en[0] <= en0_d;
            wr_addr[7:0] <= addr0_d;
            for (int i = 1; i < W; i++) begin
                wr_en[i] <= SKEW ? wr_en[i-1] : en0_d;
                wr_addr[i*8 +: 8] <= SKEW ? wr_addr[(i-1)*8 +: 8] : addr0_d;
            end
        end
    end
    assign io.wr_en = wr_en;
    assign io.wr_addr = wr_addr;
    assign io.busy = busy;
    assign io.done = done;
endmodule

// File: tb/tb_output_mem_wr_ctrl.sv
// tb_output_mem_wr_ctrl: directed plan plus random commands against a cycle-indexed expectation table.
module tb_output_mem_wr_ctrl;
    localparam int W = 4;
    localparam int DEPTH = 4096;
`ifdef OUTMEM_WR_SKEW_EN
    localparam int S = 1;
`else
    localparam int S = 0;
`endif
    logic clk = 1'b0;
    logic reset_n;
    output_mem_wr_if #(.WIDTH_HEIGHT(W)) io();
    output_mem_wr_ctrl #(.WIDTH_HEIGHT(W)) dut (.clk(clk), .reset_n(reset_n), .io(io.slave));
    always #5 clk = ~clk;

    int n_chk = 0;
    int n_pass = 0;
    int cyc = 0;
    int free_at = 0;
    bit [W-1:0] en_m [DEPTH];
    bit [7:0] addr_m [DEPTH][W];
    bit busy_m [DEPTH];
    bit done_m [DEPTH];
    bit [7:0] held [W];

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at cycle %0d", tag, got, exp, cyc);
    endtask

    // Expectations are laid out per command: row r of column i lands at T+1+r+i*S.
    always @(posedge clk) begin
        int n, d;
        logic [7:0] b;
        logic [W*8-1:0] ea;
        cyc++;
        if (reset_n && io.start && cyc >= free_at) begin
            n = int'(io.num_rows);
            b = io.base_addr;
            d = S * (W - 1);
            if (n == 0) begin
                done_m[cyc+1] = 1'b1;
                free_at = cyc + 1;
            end else begin
                for (int r = 0; r < n; r++)
                    for (int i = 0; i < W; i++) begin
                        en_m[cyc+1+r+i*S][i] = 1'b1;
                        addr_m[cyc+1+r+i*S][i] = b + 8'(r);
                    end
                for (int k = 1; k <= n + d; k++) busy_m[cyc+k] = 1'b1;
                done_m[cyc+n+d] = 1'b1;
                free_at = cyc + n + d + 2;
            end
        end
        #1;
        for (int i = 0; i < W; i++) begin
            if (en_m[cyc][i]) held[i] = addr_m[cyc][i];
            ea[i*8 +: 8] = held[i];
        end
        chk("wr_en", 64'(io.wr_en), 64'(en_m[cyc]));
        chk("wr_addr", 64'(io.wr_addr), 64'(ea));
        chk("busy", 64'(io.busy), 64'(busy_m[cyc]));
        chk("done", 64'(io.done), 64'(done_m[cyc]));
    end

    always @(negedge reset_n) begin
        for (int k = cyc; k < DEPTH; k++) begin
            en_m[k] = '0;
            busy_m[k] = 1'b0;
            done_m[k] = 1'b0;
        end
        for (int i = 0; i < W; i++) held[i] = 8'd0;
        free_at = 0;
    end

    task automatic cmd(input logic [7:0] b, input logic [7:0] n);
        @(negedge clk);
        io.start = 1'b1;
        io.base_addr = b;
        io.num_rows = n;
        @(negedge clk);
        io.start = 1'b0;
    endtask

    task automatic idle(input int k);
        repeat (k) @(negedge clk);
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_wr_en"}, 64'(io.wr_en), 64'd0);
        chk({tag, "_wr_addr"}, 64'(io.wr_addr), 64'd0);
        chk({tag, "_busy"}, 64'(io.busy), 64'd0);
        chk({tag, "_done"}, 64'(io.done), 64'd0);
    endtask

    initial begin
        bit prev_zero;
        reset_n = 1'b0;
        io.start = 1'b0;
        io.base_addr = 8'd0;
        io.num_rows = 8'd0;
        idle(3);
        chk_zero("reset");
        reset_n = 1'b1;
        idle(2);
        // reset dropped mid-ISSUE must clear everything at once
        cmd(8'h10, 8'd3);
        @(posedge clk);
        #2 reset_n = 1'b0;
        #1 chk_zero("async_rst");
        @(negedge clk);
        reset_n = 1'b1;
        idle(2);
        cmd(8'h10, 8'd3);
        idle(10);
        cmd(8'd254, 8'd4);
        idle(10);
        cmd(8'd250, 8'd10);
        idle(16);
        cmd(8'h33, 8'd0);
        idle(3);
        // start while busy is dropped; the next one lands on the first idle cycle
        cmd(8'h20, 8'd5);
        idle(2);
        cmd(8'h40, 8'd7);
        for (int k = 0; k < 50 && io.busy; k++) @(negedge clk);
        chk("busy_timeout", 64'(io.busy), 64'd0);
        io.start = 1'b1;
        io.base_addr = 8'h60;
        io.num_rows = 8'd2;
        @(negedge clk);
        io.start = 1'b0;
        idle(12);
        prev_zero = 1'b0;
        for (int it = 0; it < 700; it++) begin
            @(negedge clk);
            if ($urandom_range(199) == 0) begin
                io.start = 1'b0;
                reset_n = 1'b0;
                @(negedge clk);
                reset_n = 1'b1;
                prev_zero = 1'b0;
            end else begin
                io.start = !prev_zero && $urandom_range(3) == 0;
                io.base_addr = 8'($urandom);
                io.num_rows = $urandom_range(7) == 0 ? 8'd0 :
                              $urandom_range(15) == 0 ? 8'd40 : 8'($urandom_range(12, 1));
                prev_zero = io.start && io.num_rows == 8'd0;
            end
        end
        @(negedge clk);
        io.start = 1'b0;
        idle(60);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/output_mem_wr_ctrl.md
# output_mem_wr_ctrl

Write-side sequencer for the output memory array. It sits between the systolic array's accumulator outputs and the output memory bank: it turns one `start` command into per-column write enables and write addresses. In the default build the enables and addresses are diagonally skewed to match the wavefront leaving the array, so column `i` writes row `r` exactly `i` cycles after column 0 does. Write data passes straight from the array to the memory and is not touched by this block.

## Interface
- `WIDTH_HEIGHT`, default 4: number of columns, which is also the number of memory banks.
- `clk` input, 1 bit: rising-edge clock.
- `reset_n` input, 1 bit: asynchronous, active-low reset.
- `start` input, 1 bit: single-cycle command pulse. Accepted only in IDLE.
- `base_addr` input, 8 bits: first row address. Sampled when `start` is accepted.
- `num_rows` input, 8 bits: number of result rows to write, 0 to 255. Sampled when `start` is accepted.
- `wr_en` output, `WIDTH_HEIGHT` bits: per-bank write enable. Bit `i` drives bank `i`.
- `wr_addr` output, `WIDTH_HEIGHT*8` bits: per-bank write address. Slice `[i*8+7:i*8]` drives bank `i`.
- `busy` output, 1 bit: high from the cycle after `start` is accepted until `done`, inclusive.
- `done` output, 1 bit: one-cycle pulse when the final write of the last column is issued.

## Operation
- **States:** IDLE, ISSUE, DRAIN.
- **IDLE:**
  - On `start`, latch `base_addr` into `addr_q` and `num_rows` into `rows_q`, then clear `row_cnt`.
  - If `num_rows`=0, pulse `done` on the next cycle, issue no writes, and stay in IDLE.
  - Otherwise go to ISSUE.
- **ISSUE:**
  - Each cycle, the column-0 lead stage issues `en0=1` and `addr0=addr_q+row_cnt`, computed modulo 256.
  - `row_cnt` increments each cycle.
  - When `row_cnt==rows_q-1`, go to DRAIN.
- **Skew pipeline:**
  - Column `i` takes column `i-1`'s enable/address from one cycle earlier.
  - This is a shift register of depth `WIDTH_HEIGHT-1`, and every stage is reset.
- **DRAIN:**
  - A drain counter counts `WIDTH_HEIGHT-1` cycles while the skew pipeline empties.
  - `done` pulses on the cycle that `wr_en[WIDTH_HEIGHT-1]` is high for the last row.
  - The FSM returns to IDLE on the following cycle.
  - If `WIDTH_HEIGHT`=1, DRAIN lasts zero cycles.
- **Address arithmetic:** 8-bit and wrap-around. With `base_addr`=250 and `num_rows`=10, addresses run 250…255 and then 0…3, with no error flag.
- **Busy-time `start`:** a `start` while `busy` is ignored, including on the `done` cycle. A new command is accepted on the first cycle back in IDLE.
- **Stable addresses:** `wr_addr` for a column holds its last value when that column's `wr_en` is 0. Banks must ignore the address when their enable is 0.
- **Reset mid-operation:** `reset_n` low forces, immediately and asynchronously:
  - all `wr_en`, `wr_addr`, `busy`, `done` and counters to 0;
  - the skew pipeline to 0;
  - the FSM to IDLE.

  Partially written rows are not completed.

## Timing
- **Reset values:** `wr_en`=0, `wr_addr`=0, `busy`=0, `done`=0, state IDLE.
- **Command latency:** `start` is sampled at edge T.
  - `busy` and `wr_en[0]` (row 0) are high after edge T+1.
  - `wr_en[i]` for row 0 is high after edge T+1+i.
- **Per-column write window:** column `i` is enabled for `num_rows` consecutive cycles, starting at T+1+i.
- **Command length:** the last write is at T+`num_rows`+`WIDTH_HEIGHT`-1. `done` is in that same cycle, and `busy` falls one cycle later.
- **Throughput:** one row per cycle per column, with no bubbles.
- **Back-to-back commands:** minimum gap between accepted `start`s is `num_rows`+`WIDTH_HEIGHT`+1 cycles.
- **Output registers:** every output is driven directly from a flop.

## Configuration
- **`OUTMEM_WR_SKEW_EN` defined (default build):** diagonal skew exactly as described above.
- **`OUTMEM_WR_SKEW_EN` undefined:**
  - No skew pipeline; every column mirrors column 0 in the same cycle.
  - DRAIN is skipped, and `done` pulses with the last row, at T+`num_rows`.
  - Use this build when the array output has been de-skewed upstream.

## Test plan
- **Reset mid-operation:** assert reset, then `start` with `base_addr`=0x10 and `num_rows`=3, W=4 (skew build). Drop `reset_n` during ISSUE. All outputs must be 0 immediately, and the next `start` must behave normally.
- **Basic skewed command:** `start` with `base_addr`=0x10 and `num_rows`=3, W=4 (skew build).
  - `wr_en[0]` is high at T+1..T+3 with addresses 0x10, 0x11, 0x12.
  - `wr_en[3]` is high at T+4..T+6 with the same addresses.
  - `done` pulses at T+6 and `busy` falls at T+7.
- **Wrap-around:** `base_addr`=254, `num_rows`=4. Each column writes addresses 254, 255, 0, 1.
- **Zero rows:** `num_rows`=0. No `wr_en` is ever asserted, `done` pulses at T+1, and `busy` stays 0.
- **Start while busy:** issue `start` while busy, then a valid `start` on the first cycle back in IDLE. The busy-time `start` has no effect, and the second command is accepted with correct timing.
- **No-skew build:** same command as the basic test, built without `OUTMEM_WR_SKEW_EN`. All four `wr_en` bits are high at T+1..T+3 and `done` pulses at T+3.
